img_frame_ctrl: RTL
===================

Name: img_frame_ctrl

Overview:
- Frame sequencer and configuration controller for the camera image-processing datapath.
- Sits between the sensor capture stage and the image processing module.
- Derives pixel X/Y coordinates from the data-valid stream and frames each image with start/end pulses.
- Gates the 2x2/kernel tap-valid so the datapath only computes outside the zero-padded border, and applies filter-mode changes atomically at frame boundaries via a req/ack handshake.

Parameters:
- ROW_LENGTH, 1280, pixels per line.
- ROWS, 960, lines per frame.
- BORDER, 1, leading rows/cols with no valid tap output (kernel size minus 1).
- RST_MODE, 0, filter mode after reset.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- iFVAL  in  1  frame valid from capture.
- iDVAL  in  1  pixel valid; one pixel per cycle when high.
- iCFG_REQ  in  1  mode change request, level, held until ack.
- iCFG_MODE  in  2  requested filter mode.
- oX_Cont  out  11  column of the pixel currently on iDVAL.
- oY_Cont  out  11  row of the pixel currently on iDVAL.
- oTAP_EN  out  1  datapath output valid for this beat.
- oMODE  out  2  active filter mode.
- oCFG_ACK  out  1  one-cycle pulse when the pending mode is applied.
- oSOF  out  1  one-cycle start-of-frame pulse.
- oEOF  out  1  one-cycle end-of-frame pulse.
- oFRAME_ERR  out  1  sticky frame-length error.

Behaviour:
- Reset (async, iRST=1): state IDLE; x=y=0; oMODE=RST_MODE; oSOF, oEOF, oCFG_ACK, oFRAME_ERR = 0; pending flag = 0. Reset mid-frame abandons the frame; the next frame is accepted only after iFVAL is seen low.
- Registered fval_d tracks iFVAL; its reset value is 1, so a frame already in progress at reset release is not entered.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - iFVAL=1 and fval_d=0 -> ACTIVE next cycle.
  - oSOF pulses in the cycle ACTIVE is entered.
  - oFRAME_ERR clears in that same cycle.
  - x=y=0.
- ACTIVE:
  - Each iDVAL beat advances the counters: x++; at x==ROW_LENGTH-1, x<=0 and y++.
  - oX_Cont/oY_Cont are the counter registers, i.e. the coordinate of the beat presented this cycle.
  - Beat at x==ROW_LENGTH-1, y==ROWS-1 -> DONE; oEOF pulses next cycle; counters reset to 0.
  - iFVAL falls before the last beat -> IDLE, oFRAME_ERR<=1, no oEOF.
- DONE:
  - Wait for iFVAL=0 -> IDLE.
  - Any iDVAL beat in DONE sets oFRAME_ERR; pixel ignored, counters hold 0.
- oTAP_EN (combinational) = iDVAL & (state==ACTIVE) & (oX_Cont>=BORDER) & (oY_Cont>=BORDER). iDVAL while IDLE/DONE gives oTAP_EN=0.
- Config handshake:
  - iCFG_REQ=1 with no pending -> latch iCFG_MODE into pending register, pending=1.
  - While pending, a changed iCFG_MODE overwrites the pending value (last value wins).
  - Apply point: the IDLE->ACTIVE transition cycle, or any cycle in IDLE if pending. oMODE<=pending value, oCFG_ACK pulses 1 cycle, pending clears.
  - oMODE never changes in ACTIVE or DONE.
  - Requester drops iCFG_REQ after ack. REQ still high the cycle after ack -> treated as a new request.
- Simultaneous SOF and apply in the same cycle: new mode and oSOF assert together; the first pixel of the frame uses the new mode.
- Widths: counters 11 bits. ROW_LENGTH and ROWS must be at most 2048; no counter wrap beyond the parameters is possible.

Test Plan:
- Nominal frame: ROW_LENGTH=8, ROWS=4, BORDER=1, iFVAL high then 32 contiguous beats -> oSOF once; oX_Cont cycles 0..7, oY_Cont 0..3; oTAP_EN high on 21 beats (x>=1,y>=1); oEOF one pulse after beat (7,3); oFRAME_ERR=0.
- Gapped iDVAL: same frame with iDVAL low every 3rd cycle -> identical coordinate sequence and 21 tap beats; counters hold across gaps.
- Short frame: iFVAL drops after 20 beats -> state IDLE, oFRAME_ERR=1, no oEOF. Next full frame -> oFRAME_ERR clears at oSOF and the frame completes normally.
- Mode change mid-frame: iCFG_REQ=1, iCFG_MODE=2 at beat 10 -> oMODE stays 0 through oEOF. oCFG_ACK and oMODE=2 in IDLE after iFVAL low, before the next oSOF.
- Overwrite: REQ with mode 1 then mode 3 during ACTIVE -> single ack; oMODE=3.
- Async reset mid-frame: iRST pulse at beat 12 while iFVAL stays high -> outputs 0 and oMODE=RST_MODE immediately. No oSOF until iFVAL goes low then high; the following frame counts from (0,0).

Source files
------------

// File: rtl/img_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : img_frame_ctrl
// Brief    : Frame sequencer for the image datapath: pixel coordinates,
//            SOF/EOF framing, border tap gating and frame-boundary mode change.
// Revision : 1.0 - initial release
// ============================================================================
module img_frame_ctrl #(
  parameter int         ROW_LENGTH = 1280,
  parameter int         ROWS       = 960,
  parameter int         BORDER     = 1,
  parameter logic [1:0] RST_MODE   = 2'd0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic        iCFG_REQ,
  input  logic [1:0]  iCFG_MODE,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oTAP_EN,
  output logic [1:0]  oMODE,
  output logic        oCFG_ACK,
  output logic        oSOF,
  output logic        oEOF,
  output logic        oFRAME_ERR
);

  localparam logic [1:0]  c_IDLE   = 2'd0;
  localparam logic [1:0]  c_ACTIVE = 2'd1;
  localparam logic [1:0]  c_DONE   = 2'd2;
  localparam logic [10:0] c_X_LAST = 11'(ROW_LENGTH - 1);
  localparam logic [10:0] c_Y_LAST = 11'(ROWS - 1);
  localparam logic [10:0] c_BORDER = 11'(BORDER);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_fval_d;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_sof;
  logic        r_eof;
  logic        r_err;
  logic        r_ack;
  logic [1:0]  r_mode;
  logic        r_pend;
  logic [1:0]  r_pend_mode;

  logic w_start;
  logic w_beat;
  logic w_row_end;
  logic w_last_beat;
  logic w_abort;
  logic w_apply;
  logic w_tap_en;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a dropped frame-valid wins over a final beat
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_start) begin
          w_state_next = c_ACTIVE;
        end
      end
      c_ACTIVE: begin
        if (!iFVAL) begin
          w_state_next = c_IDLE;
        end else if (w_last_beat) begin
          w_state_next = c_DONE;
        end
      end
      c_DONE: begin
        if (!iFVAL) begin
          w_state_next = c_IDLE;
        end
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    w_start     = (r_state == c_IDLE) && iFVAL && !r_fval_d;
    w_beat      = (r_state == c_ACTIVE) && iDVAL;
    w_row_end   = (r_x == c_X_LAST);
    w_last_beat = w_beat && w_row_end && (r_y == c_Y_LAST);
    w_abort     = (r_state == c_ACTIVE) && !iFVAL;
    w_apply     = (r_state == c_IDLE) && r_pend;
    w_tap_en    = w_beat && (r_x >= c_BORDER) && (r_y >= c_BORDER);
  end

  // Coordinate counters are held at zero outside an active frame
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_x <= '0;
      r_y <= '0;
    end else if ((r_state != c_ACTIVE) || w_abort) begin
      r_x <= '0;
      r_y <= '0;
    end else if (iDVAL) begin
      if (w_row_end) begin
        r_x <= '0;
        r_y <= (r_y == c_Y_LAST) ? 11'd0 : r_y + 11'd1;
      end else begin
        r_x <= r_x + 11'd1;
      end
    end
  end

  // fval_d resets high so a frame already running at reset release is skipped
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_fval_d <= 1'b1;
      r_sof    <= 1'b0;
      r_eof    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_fval_d <= iFVAL;
      r_sof    <= w_start;
      r_eof    <= iFVAL && w_last_beat;
      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_abort || ((r_state == c_DONE) && iDVAL)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Mode handshake; the ack cycle itself is not taken as a fresh request
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_mode      <= RST_MODE;
      r_pend      <= 1'b0;
      r_pend_mode <= RST_MODE;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_mode <= r_pend_mode;
        r_pend <= 1'b0;
      end else if (r_pend) begin
        if (iCFG_REQ) begin
          r_pend_mode <= iCFG_MODE;
        end
      end else if (iCFG_REQ && !r_ack) begin
        r_pend      <= 1'b1;
        r_pend_mode <= iCFG_MODE;
      end
    end
  end

  assign oX_Cont    = r_x;
  assign oY_Cont    = r_y;
  assign oTAP_EN    = w_tap_en;
  assign oMODE      = r_mode;
  assign oCFG_ACK   = r_ack;
  assign oSOF       = r_sof;
  assign oEOF       = r_eof;
  assign oFRAME_ERR = r_err;

endmodule
`default_nettype wire
